line_draw_scheduler: RTL and testbench
======================================

Name: line_draw_scheduler

Overview:
- Arbitrates line-draw commands from two requesters (e.g. host register port and demo pattern generator) and sequences the Bresenham line engine one command at a time.
- Launches new lines only while the VGA timing generator reports vertical blanking, when VBLNK_ONLY=1, so frame-buffer writes do not tear the visible 800x600 image.
- Sits between the command sources, the VGA timing block (vblnk) and the line engine.

Parameters:
- CW, 11, coordinate width (matches the hcount/vcount width).
- COLW, 12, colour word width.
- H_ACTIVE, 800, visible pixels per line; x coordinates must be < H_ACTIVE.
- V_ACTIVE, 600, visible lines; y coordinates must be < V_ACTIVE.
- VBLNK_ONLY, 1, 1 = launch only while vblnk=1; 0 = launch any time.

Ports:
- pclk  input  1  pixel clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- vblnk  input  1  vertical blank from the VGA timing block, synchronous to pclk.
- req0_valid  input  1  requester 0 command valid.
- req0_ready  output  1  requester 0 command accepted when high together with valid.
- req0_cmd  input  4*CW+COLW  requester 0 command {x0,y0,x1,y1,colour}, MSB first.
- req1_valid  input  1  requester 1 command valid.
- req1_ready  output  1  requester 1 command accepted when high together with valid.
- req1_cmd  input  4*CW+COLW  requester 1 command, same format as req0_cmd.
- eng_start  output  1  one-cycle launch pulse to the line engine.
- eng_cmd  output  4*CW+COLW  latched command; stable from eng_start until eng_done.
- eng_done  input  1  one-cycle completion pulse from the line engine.
- busy  output  1  high when the state is not IDLE.
- frame_lines  output  8  lines launched since the last vblnk rising edge; saturates at 255.
- clip_err  output  1  sticky: a command with an out-of-range coordinate was dropped.
- proto_err  output  1  sticky: eng_done arrived outside the WAIT state.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE; eng_start=0; eng_cmd=0; frame_lines=0; clip_err=0; proto_err=0; last_grant=1 (requester 0 wins first).
  - busy=0; req0_ready=0 and req1_ready=0 while rst=1.
- launch_ok = (VBLNK_ONLY==0) || vblnk.
- Grant (combinational, IDLE only):
  - Only one requester valid: that requester wins.
  - Both valid: the requester other than last_grant wins (round-robin).
- reqN_ready = (state==IDLE) && launch_ok && (grant==N). It is combinational and never high for both requesters in the same cycle.
- On transfer (valid && ready) in cycle T:
  - The command is latched into eng_cmd and last_grant is set to N.
  - Any x0 or x1 >= H_ACTIVE, or any y0 or y1 >= V_ACTIVE: set clip_err, stay in IDLE, no launch.
  - Otherwise: state -> LAUNCH.
- States:
  - IDLE: wait for a transfer.
  - LAUNCH (1 cycle): eng_start=1 in cycle T+1; frame_lines increments (saturating); state -> WAIT.
  - WAIT: hold eng_cmd; on eng_done -> IDLE, and the next transfer is possible in the following cycle.
- eng_done in the same cycle as eng_start is not legal. It is ignored and sets proto_err.
- eng_done in IDLE or LAUNCH: ignored; sets proto_err.
- A line in WAIT continues through the vblnk falling edge. Gating applies to launches only.
- vblnk rising edge (registered previous vblnk): frame_lines clears to 0.
  - If a launch occurs in the same cycle, frame_lines = 1 (clear wins first, then increment).
- Degenerate lines (x0==x1 and y0==y1) are launched normally.
- Throughput: at most one line per (engine latency + 2) cycles.
- Requester commands are not buffered. A requester holds valid and cmd stable until ready.

Test Plan:
- Reset, then VBLNK_ONLY=1 and vblnk=0, req0_valid=1 -> req0_ready=0 and no eng_start. Raise vblnk -> req0_ready=1 the same cycle, eng_start in the next cycle, eng_cmd equals req0_cmd, frame_lines=1.
- Both requesters valid continuously, engine returning done 5 cycles after start -> grants alternate 0,1,0,1. Each eng_start is 7 cycles after the previous one, and ready is never high for both requesters.
- Command {x0=10,y0=20,x1=800,y1=5} -> clip_err=1, no eng_start, frame_lines unchanged. The next valid command {0,0,799,599} launches.
- Line in WAIT when vblnk falls -> eng_cmd is held until eng_done and the FSM returns to IDLE. req_ready stays 0 until vblnk rises again.
- eng_done pulsed while IDLE -> proto_err=1 (sticky), state unchanged. Assert rst mid-WAIT -> all outputs return to reset values immediately, without waiting for a clock edge.
- 300 launches within one vblnk period -> frame_lines saturates at 255. A vblnk rising edge together with a launch -> frame_lines=1.

Source files
------------

// File: rtl/line_draw_scheduler.sv
// rtl/line_draw_scheduler.sv - round-robin, vblank-gated command launcher for the line engine
module line_draw_scheduler #(
  parameter int CW         = 11,
  parameter int COLW       = 12,
  parameter int H_ACTIVE   = 800,
  parameter int V_ACTIVE   = 600,
  parameter int VBLNK_ONLY = 1
) (
  input  logic                 pclk,
  input  logic                 rst,
  input  logic                 vblnk,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [4*CW+COLW-1:0] req0_cmd,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [4*CW+COLW-1:0] req1_cmd,
  output logic                 eng_start,
  output logic [4*CW+COLW-1:0] eng_cmd,
  input  logic                 eng_done,
  output logic                 busy,
  output logic [7:0]           frame_lines,
  output logic                 clip_err,
  output logic                 proto_err
);
  localparam int CMDW = 4*CW+COLW;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

  state_t          state_q, state_d;
  logic [CMDW-1:0] cmd_q, cmd_d, sel_cmd;
  logic            last_grant_q, last_grant_d;
  logic            vblnk_q;
  logic [7:0]      frame_lines_q, frame_lines_d;
  logic            clip_err_q, clip_err_d;
  logic            proto_err_q, proto_err_d;
  logic            grant, launch_ok, xfer, in_range, vblnk_rise;
  logic [CW-1:0]   x0, y0, x1, y1;

  assign {x0, y0, x1, y1} = sel_cmd[CMDW-1:COLW];
  assign in_range = (x0 < CW'(H_ACTIVE)) && (x1 < CW'(H_ACTIVE)) &&
                    (y0 < CW'(V_ACTIVE)) && (y1 < CW'(V_ACTIVE));
  assign vblnk_rise = vblnk && !vblnk_q;

  assign eng_start   = (state_q == LAUNCH);
  assign busy        = (state_q != IDLE);
  assign eng_cmd     = cmd_q;
  assign frame_lines = frame_lines_q;
  assign clip_err    = clip_err_q;
  assign proto_err   = proto_err_q;

  // Ready is masked by rst directly so it drops the moment reset is asserted.
  always_comb begin
    launch_ok = (VBLNK_ONLY == 0) || vblnk;
    if (req0_valid && !req1_valid)
      grant = 1'b0;
    else if (req1_valid && !req0_valid)
      grant = 1'b1;
    else
      grant = !last_grant_q;
    sel_cmd    = grant ? req1_cmd : req0_cmd;
    req0_ready = !rst && (state_q == IDLE) && launch_ok && !grant;
    req1_ready = !rst && (state_q == IDLE) && launch_ok && grant;
    xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  end

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    last_grant_d = last_grant_q;
    clip_err_d   = clip_err_q;
    proto_err_d  = proto_err_q;
    case (state_q)
      IDLE: begin
        if (eng_done)
          proto_err_d = 1'b1;
        if (xfer) begin
          cmd_d        = sel_cmd;
          last_grant_d = grant;
          if (in_range)
            state_d = LAUNCH;
          else
            clip_err_d = 1'b1;
        end
      end
      LAUNCH: begin
        if (eng_done)
          proto_err_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (eng_done)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A vblank rising edge clears the count before the launch in the same cycle adds to it.
  always_comb begin
    frame_lines_d = vblnk_rise ? 8'd0 : frame_lines_q;
    if ((state_q == LAUNCH) && (frame_lines_d != 8'hFF))
      frame_lines_d = frame_lines_d + 8'd1;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      last_grant_q  <= 1'b1;
      vblnk_q       <= 1'b0;
      frame_lines_q <= 8'd0;
      clip_err_q    <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      last_grant_q  <= last_grant_d;
      vblnk_q       <= vblnk;
      frame_lines_q <= frame_lines_d;
      clip_err_q    <= clip_err_d;
      proto_err_q   <= proto_err_d;
    end
  end
endmodule

// File: tb/tb_line_draw_scheduler.sv
// tb/tb_line_draw_scheduler.sv - directed self-checking bench for line_draw_scheduler
module tb_line_draw_scheduler;
  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        vblnk = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [55:0] req0_cmd = '0, req1_cmd = '0;
  logic        eng_start;
  logic [55:0] eng_cmd;
  logic        eng_done;
  logic        busy;
  logic [7:0]  frame_lines;
  logic        clip_err, proto_err;
  logic        man_done = 1'b0, auto_done = 1'b0, auto_en = 1'b0;
  int          total = 0, bad = 0;

  assign eng_done = man_done | auto_done;

  line_draw_scheduler dut (
    .pclk(pclk), .rst(rst), .vblnk(vblnk),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd),
    .eng_start(eng_start), .eng_cmd(eng_cmd), .eng_done(eng_done),
    .busy(busy), .frame_lines(frame_lines), .clip_err(clip_err), .proto_err(proto_err)
  );

  always #5 pclk = ~pclk;

  // Engine stand-in: done is high exactly 5 cycles after the start cycle.
  initial begin
    forever begin
      @(negedge pclk);
      if (auto_en && eng_start) begin
        repeat (5) @(posedge pclk);
        #1 auto_done = 1'b1;
        @(posedge pclk);
        #1 auto_done = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 30) begin
      tick();
      n++;
    end
    check(tag, {63'd0, busy}, 64'd0);
  endtask

  function automatic logic [55:0] mk(input int x0, input int y0, input int x1, input int y1, input int col);
    return {11'(x0), 11'(y0), 11'(x1), 11'(y1), 12'(col)};
  endfunction

  initial begin
    int nst, both, n;
    int st_cyc[4];
    logic g[4];

    // reset values, ready masked while rst is high
    vblnk = 1'b1; req0_valid = 1'b1;
    #2;
    check("rst_ready0", {63'd0, req0_ready}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_start", {63'd0, eng_start}, 64'd0);
    check("rst_cmd", {8'd0, eng_cmd}, 64'd0);
    check("rst_lines", {56'd0, frame_lines}, 64'd0);
    check("rst_errs", {62'd0, clip_err, proto_err}, 64'd0);
    req0_valid = 1'b0; vblnk = 1'b0;
    tick();
    rst = 1'b0;

    // launch held off until vblank
    req0_cmd = mk(1, 2, 3, 4, 12'hABC); req0_valid = 1'b1;
    #1;
    check("gate_ready", {63'd0, req0_ready}, 64'd0);
    tick();
    check("gate_start", {63'd0, eng_start}, 64'd0);
    vblnk = 1'b1;
    #1;
    check("vb_ready", {63'd0, req0_ready}, 64'd1);
    tick();
    req0_valid = 1'b0;
    check("vb_start", {63'd0, eng_start}, 64'd1);
    check("vb_cmd", {8'd0, eng_cmd}, {8'd0, mk(1, 2, 3, 4, 12'hABC)});
    tick();
    check("vb_lines", {56'd0, frame_lines}, 64'd1);
    check("vb_start_1cyc", {63'd0, eng_start}, 64'd0);
    man_done = 1'b1; tick(); man_done = 1'b0;
    check("vb_idle", {63'd0, busy}, 64'd0);
    check("vb_proto", {63'd0, proto_err}, 64'd0);

    // round-robin with a 5-cycle engine
    do_reset();
    req0_cmd = mk(5, 5, 6, 6, 12'h000); req1_cmd = mk(7, 7, 8, 8, 12'h111);
    req0_valid = 1'b1; req1_valid = 1'b1; auto_en = 1'b1;
    nst = 0; both = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (req0_ready && req1_ready) both++;
      if (eng_start && nst < 4) begin
        st_cyc[nst] = c;
        g[nst] = eng_cmd[0];
        nst++;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("rr_count", 64'(nst), 64'd4);
    check("rr_both_ready", 64'(both), 64'd0);
    check("rr_g0", {63'd0, g[0]}, 64'd0);
    check("rr_g1", {63'd0, g[1]}, 64'd1);
    check("rr_g2", {63'd0, g[2]}, 64'd0);
    check("rr_g3", {63'd0, g[3]}, 64'd1);
    for (int i = 1; i < 4; i++)
      check("rr_gap", 64'(st_cyc[i] - st_cyc[i-1]), 64'd7);
    wait_idle("rr_drain");
    auto_en = 1'b0;

    // out-of-range command dropped, next in-range command launches
    do_reset();
    req0_cmd = mk(10, 20, 800, 5, 0); req0_valid = 1'b1;
    #1;
    check("clip_ready", {63'd0, req0_ready}, 64'd1);
    tick();
    check("clip_err", {63'd0, clip_err}, 64'd1);
    check("clip_start", {63'd0, eng_start}, 64'd0);
    check("clip_busy", {63'd0, busy}, 64'd0);
    check("clip_lines", {56'd0, frame_lines}, 64'd0);
    req0_cmd = mk(0, 0, 799, 599, 12'h5A5);
    tick();
    req0_valid = 1'b0;
    check("edge_start", {63'd0, eng_start}, 64'd1);
    check("edge_cmd", {8'd0, eng_cmd}, {8'd0, mk(0, 0, 799, 599, 12'h5A5)});
    tick();
    check("edge_lines", {56'd0, frame_lines}, 64'd1);

    // vblank falls while the line is in progress
    vblnk = 1'b0;
    tick(); tick();
    check("hold_busy", {63'd0, busy}, 64'd1);
    check("hold_cmd", {8'd0, eng_cmd}, {8'd0, mk(0, 0, 799, 599, 12'h5A5)});
    man_done = 1'b1; tick(); man_done = 1'b0;
    check("hold_idle", {63'd0, busy}, 64'd0);
    req1_cmd = mk(3, 3, 3, 3, 12'h333); req1_valid = 1'b1;
    #1;
    check("novb_ready", {63'd0, req1_ready}, 64'd0);
    tick();
    check("novb_start", {63'd0, eng_start}, 64'd0);
    vblnk = 1'b1;
    #1;
    check("revb_ready1", {63'd0, req1_ready}, 64'd1);
    check("revb_ready0", {63'd0, req0_ready}, 64'd0);
    tick();
    req1_valid = 1'b0;
    check("degen_start", {63'd0, eng_start}, 64'd1);
    check("degen_cmd", {8'd0, eng_cmd}, {8'd0, mk(3, 3, 3, 3, 12'h333)});
    tick();
    check("revb_lines", {56'd0, frame_lines}, 64'd1);
    man_done = 1'b1; tick(); man_done = 1'b0;

    // done while idle, then async reset mid-line
    man_done = 1'b1; tick(); man_done = 1'b0;
    check("proto_err", {63'd0, proto_err}, 64'd1);
    check("proto_idle", {63'd0, busy}, 64'd0);
    tick();
    check("proto_sticky", {63'd0, proto_err}, 64'd1);
    req0_cmd = mk(1, 1, 2, 2, 1); req0_valid = 1'b1;
    tick(); tick();
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_ready", {63'd0, req0_ready}, 64'd0);
    check("arst_cmd", {8'd0, eng_cmd}, 64'd0);
    check("arst_lines", {56'd0, frame_lines}, 64'd0);
    check("arst_proto", {63'd0, proto_err}, 64'd0);
    tick();
    rst = 1'b0; req0_valid = 1'b0;

    // 300 launches in one vblank, then a rising edge with a transfer
    do_reset();
    req0_cmd = mk(4, 4, 9, 9, 7); req0_valid = 1'b1; auto_en = 1'b1;
    n = 0;
    for (int c = 0; c < 2600 && n < 300; c++) begin
      tick();
      if (eng_start) n++;
    end
    req0_valid = 1'b0;
    check("sat_count", 64'(n), 64'd300);
    wait_idle("sat_drain");
    check("sat_lines", {56'd0, frame_lines}, 64'd255);
    vblnk = 1'b0;
    tick();
    req0_valid = 1'b1; vblnk = 1'b1;
    #1;
    check("rise_ready", {63'd0, req0_ready}, 64'd1);
    tick();
    req0_valid = 1'b0;
    check("rise_clear", {56'd0, frame_lines}, 64'd0);
    tick();
    check("rise_lines", {56'd0, frame_lines}, 64'd1);
    wait_idle("rise_drain");
    auto_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
